bit_filter: RTL and testbench

- Multi-channel digital glitch filter on the system bit bus, directly upstream of the LUT block; its outputs drive the LUT's inpa_i..inpe_i.
- Each channel only changes its output after its input has held the new level for a programmable number of consecutive clocks.
- Provides single-cycle rise/fall event pulses per channel for edge-sensitive consumers.
- DELAY programmed through the usual register-plus-write-strobe pair.

---
 rtl/bit_filter.sv | 125 ++++++++++++
 tb/tb_bit_filter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_filter.sv
// Multi-channel glitch filter: each output follows its input only after max(DELAY,1) stable samples.
// Optional per-channel glitch counters are built when BIT_FILTER_GLITCH_CNT_EN is defined.
module bit_filter #(
    parameter int N_CH  = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [N_CH-1:0]   inp_i,
    input  logic [CNT_W-1:0]  DELAY,
    input  logic              DELAY_WSTB,
    input  logic [N_CH-1:0]   ENABLE,
    output logic [N_CH-1:0]   out_o,
    output logic [N_CH-1:0]   rise_o,
    output logic [N_CH-1:0]   fall_o
`ifdef BIT_FILTER_GLITCH_CNT_EN
    ,
    output logic [N_CH*8-1:0] glitch_cnt_o
`endif
);

    logic [N_CH-1:0]  inp_q, inp_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] delay_eff;

    // DELAY=0 is treated as a one-sample qualification window.
    assign delay_eff = (DELAY == '0) ? CNT_W'(1) : DELAY;

`ifdef BIT_FILTER_GLITCH_CNT_EN
    logic [7:0]       glitch_q [N_CH];
    logic [7:0]       glitch_d [N_CH];
    logic [N_CH-1:0]  glitch_evt;
`endif

    always_comb begin
        inp_d = inp_i;
        out_d = out_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
        end
`ifdef BIT_FILTER_GLITCH_CNT_EN
        glitch_evt = '0;
`endif
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!ENABLE[ch]) begin
                out_d[ch] = inp_q[ch];
                cnt_d[ch] = '0;
            end else if (DELAY_WSTB) begin
                cnt_d[ch] = '0;
            end else if (inp_q[ch] == out_q[ch]) begin
                cnt_d[ch] = '0;
`ifdef BIT_FILTER_GLITCH_CNT_EN
                glitch_evt[ch] = (cnt_q[ch] != '0);
`endif
            end else if (({1'b0, cnt_q[ch]} + (CNT_W+1)'(1)) >= {1'b0, delay_eff}) begin
                out_d[ch] = inp_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

`ifdef BIT_FILTER_GLITCH_CNT_EN
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            glitch_d[ch] = glitch_q[ch];
            if (DELAY_WSTB) begin
                glitch_d[ch] = '0;
            end else if (glitch_evt[ch] && (glitch_q[ch] != 8'hFF)) begin
                glitch_d[ch] = glitch_q[ch] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                glitch_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                glitch_q[ch] <= glitch_d[ch];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            glitch_cnt_o[ch*8 +: 8] = glitch_q[ch];
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            inp_q  <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            inp_q  <= inp_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_bit_filter.sv
// Scoreboard bench for bit_filter: a timestamp-based stability model predicts each edge's outputs.
`timescale 1ns/1ps
module tb_bit_filter;
    localparam int N_CH  = 5;
    localparam int CNT_W = 16;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N_CH-1:0]   inp_i;
    logic [CNT_W-1:0]  DELAY;
    logic              DELAY_WSTB;
    logic [N_CH-1:0]   ENABLE;
    logic [N_CH-1:0]   out_o, rise_o, fall_o;
`ifdef BIT_FILTER_GLITCH_CNT_EN
    logic [N_CH*8-1:0] glitch_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bit_filter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .inp_i       (inp_i),
        .DELAY       (DELAY),
        .DELAY_WSTB  (DELAY_WSTB),
        .ENABLE      (ENABLE),
        .out_o       (out_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o)
`ifdef BIT_FILTER_GLITCH_CNT_EN
        ,
        .glitch_cnt_o(glitch_cnt_o)
`endif
    );

    typedef struct {
        int                edge_n;
        logic [N_CH-1:0]   o;
        logic [N_CH-1:0]   r;
        logic [N_CH-1:0]   f;
        logic [N_CH*8-1:0] g;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: each channel remembers the edge at which its stability count last restarted.
    logic [N_CH-1:0] m_inq, m_out;
    int              m_s [N_CH];
    int              m_g [N_CH];
    int              n = 1;

    logic [N_CH-1:0]  cur_i, cur_e;
    logic [CNT_W-1:0] cur_d;

    task automatic chk(input string nm, input int en, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %h expected %h", nm, en, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inq = '0;
        m_out = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_s[ch] = n - 1;
            m_g[ch] = 0;
        end
    endtask

    task automatic step(input logic [N_CH-1:0] i, input logic [CNT_W-1:0] d,
                        input logic w, input logic [N_CH-1:0] e);
        exp_t x;
        int   deff;
        logic prev;
        @(negedge clk_i);
        inp_i = i; DELAY = d; DELAY_WSTB = w; ENABLE = e;
        deff = (d == 0) ? 1 : int'(d);
        x.edge_n = n;
        x.r = '0;
        x.f = '0;
        x.g = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            prev = m_out[ch];
            if (!e[ch]) begin
                m_out[ch] = m_inq[ch];
                m_s[ch] = n;
            end else if (w) begin
                m_s[ch] = n;
            end else if (m_inq[ch] == m_out[ch]) begin
                if ((n - 1 - m_s[ch]) > 0 && m_g[ch] < 255) m_g[ch]++;
                m_s[ch] = n;
            end else if ((n - m_s[ch]) >= deff) begin
                m_out[ch] = m_inq[ch];
                m_s[ch] = n;
            end
            if (w) m_g[ch] = 0;
            x.r[ch] = !prev && m_out[ch];
            x.f[ch] = prev && !m_out[ch];
            x.g[ch*8 +: 8] = 8'(m_g[ch]);
        end
        x.o = m_out;
        m_inq = i;
        n++;
        sbq.push_back(x);
        cur_i = i; cur_d = d; cur_e = e;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out"},  n, 64'(out_o),  64'(0));
        chk({tag, "_rise"}, n, 64'(rise_o), 64'(0));
        chk({tag, "_fall"}, n, 64'(fall_o), 64'(0));
`ifdef BIT_FILTER_GLITCH_CNT_EN
        chk({tag, "_glitch"}, n, 64'(glitch_cnt_o), 64'(0));
`endif
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        inp_i = '0;
        DELAY_WSTB = 1'b0;
        reset_i = 1'b1;
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1 check_zero("async_rst");
        sbq.delete();
        model_reset();
        repeat (2) @(negedge clk_i);
        release_reset();
    endtask

    always @(posedge clk_i) begin
        exp_t x;
        #1;
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            chk("out_o",  x.edge_n, 64'(out_o),  64'(x.o));
            chk("rise_o", x.edge_n, 64'(rise_o), 64'(x.r));
            chk("fall_o", x.edge_n, 64'(fall_o), 64'(x.f));
`ifdef BIT_FILTER_GLITCH_CNT_EN
            chk("glitch_cnt_o", x.edge_n, 64'(glitch_cnt_o), 64'(x.g));
`endif
        end
    end

    initial begin
        logic [N_CH-1:0] nxt;
        reset_i = 1'b0; inp_i = '0; DELAY = 16'd4; DELAY_WSTB = 1'b0; ENABLE = 5'h1F;
        cur_i = '0; cur_d = 16'd4; cur_e = 5'h1F;
        model_reset();
        #7 check_zero("init_rst");
        release_reset();

        // Steady rise on ch0 with DELAY=4.
        for (int k = 0; k < 8; k++) step(5'h01, 16'd4, 1'b0, 5'h1F);
        // Three-sample excursion on ch1 is rejected.
        for (int k = 0; k < 3; k++) step(5'h03, 16'd4, 1'b0, 5'h1F);
        for (int k = 0; k < 4; k++) step(5'h01, 16'd4, 1'b0, 5'h1F);
        // DELAY=0 passes a single-sample pulse on ch2.
        step(5'h05, 16'd0, 1'b0, 5'h1F);
        for (int k = 0; k < 3; k++) step(5'h01, 16'd0, 1'b0, 5'h1F);
        // DELAY=10 on ch3 with a strobe mid-count restarts qualification.
        for (int k = 0; k < 5; k++) step(5'h09, 16'd10, 1'b0, 5'h1F);
        step(5'h09, 16'd10, 1'b1, 5'h1F);
        for (int k = 0; k < 14; k++) step(5'h09, 16'd10, 1'b0, 5'h1F);
        // Bypass on ch0 while others stay filtered.
        step(5'h08, 16'd100, 1'b0, 5'h1E);
        step(5'h09, 16'd100, 1'b0, 5'h1E);
        for (int k = 0; k < 4; k++) step(5'h08, 16'd100, 1'b0, 5'h1E);
        // ch4 high, then a count in progress when reset hits asynchronously.
        for (int k = 0; k < 6; k++) step(5'h18, 16'd4, 1'b0, 5'h1F);
        for (int k = 0; k < 2; k++) step(5'h08, 16'd4, 1'b0, 5'h1F);
        async_reset();
        for (int k = 0; k < 7; k++) step(5'h10, 16'd4, 1'b0, 5'h1F);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            nxt = cur_i ^ N_CH'($urandom & $urandom);
            case ($urandom_range(0, 9))
                0:       cur_d = 16'd0;
                1:       cur_d = 16'd1;
                2, 3:    cur_d = 16'd2;
                4:       cur_d = 16'd100;
                default: cur_d = cur_d;
            endcase
            if (cur_d == 16'd100 && $urandom_range(0, 3) != 0) cur_d = 16'd3;
            if ($urandom_range(0, 49) == 0) cur_e = N_CH'($urandom);
            if ($urandom_range(0, 7) == 0) nxt = cur_i;
            step(nxt, cur_d, ($urandom_range(0, 29) == 0), cur_e);
            if (k == 1500) async_reset();
        end

        @(posedge clk_i);
        #2;
        chk("sb_drain", n, 64'(sbq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
